// File: rtl/wb_timeout_bridge_if.sv
// Classic Wishbone bus bundle; slave modport faces an initiator, master faces a target.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            cyc;
    logic            stb;
    logic            ack;
    logic            err;

    modport slave  (input  adr, dat_w, sel, we, cti, bte, cyc, stb,
                    output dat_r, ack, err);
    modport master (output adr, dat_w, sel, we, cti, bte, cyc, stb,
                    input  dat_r, ack, err);
endinterface

// File: rtl/wb_timeout_bridge.sv
// Wishbone bridge that splits bursts into classic cycles and terminates stuck requests with ERR.
// One cycle request latency, one cycle response latency; upstream is stalled while a transfer is outstanding.
module wb_timeout_bridge #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 256
) (
    input  logic       clk,
    input  logic       rst,
    wb_if.slave        t,
    wb_if.master       i,
    output logic       timeout_o,
    output logic [7:0] timeout_count_o
);
    localparam int          SW      = WB_DATA_WIDTH / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                     state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic                       abort_q, abort_d;
    logic                       cyc_q, cyc_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
    logic [SW-1:0]              sel_q, sel_d;
    logic                       we_q, we_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [WB_DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
    logic                       to_q, to_d;
    logic [7:0]                 tcnt_q, tcnt_d;
    logic                       abort_now;
    logic                       unused_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_w_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
            to_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
            to_q    <= to_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        sel_d     = sel_q;
        we_d      = we_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_r_d   = '0;
        to_d      = 1'b0;
        tcnt_d    = tcnt_q;
        // An upstream drop seen in the same cycle as the response still suppresses it.
        abort_now = abort_q | ~t.cyc;
        case (state_q)
            IDLE: begin
                if (t.cyc && t.stb) begin
                    adr_d   = t.adr;
                    dat_w_d = t.dat_w;
                    sel_d   = t.sel;
                    we_d    = t.we;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    cyc_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                abort_d = abort_now;
                if (i.err) begin
                    cyc_d   = 1'b0;
                    err_d   = ~abort_now;
                    state_d = RESP;
                end else if (i.ack) begin
                    cyc_d   = 1'b0;
                    ack_d   = ~abort_now;
                    dat_r_d = abort_now ? '0 : i.dat_r;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = ~abort_now;
                    to_d    = 1'b1;
                    tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign i.cyc   = cyc_q;
    assign i.stb   = cyc_q;
    assign i.adr   = adr_q;
    assign i.dat_w = dat_w_q;
    assign i.sel   = sel_q;
    assign i.we    = we_q;
    assign i.cti   = 3'b000;
    assign i.bte   = 2'b00;

    assign t.ack   = ack_q;
    assign t.err   = err_q;
    assign t.dat_r = dat_r_q;

    assign timeout_o       = to_q;
    assign timeout_count_o = tcnt_q;

    // Burst hints are deliberately discarded; every beat becomes a classic cycle.
    assign unused_burst = ^{t.cti, t.bte};
endmodule

// File: tb/tb_wb_timeout_bridge.sv
module tb_wb_timeout_bridge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       to1, to2;
    logic [7:0] cnt1, cnt2;
    int         total = 0;
    int         bad   = 0;
    int         pulses;
    logic [7:0] v254, v255;

    wb_if #(.AW(32), .DW(32)) t_bus ();
    wb_if #(.AW(32), .DW(32)) i_bus ();
    wb_if #(.AW(32), .DW(32)) t2_bus ();
    wb_if #(.AW(32), .DW(32)) i2_bus ();

    wb_timeout_bridge #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .t(t_bus), .i(i_bus),
        .timeout_o(to1), .timeout_count_o(cnt1)
    );

    wb_timeout_bridge #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT(2)) u_dut2 (
        .clk(clk), .rst(rst), .t(t2_bus), .i(i2_bus),
        .timeout_o(to2), .timeout_count_o(cnt2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        t_bus.adr = '0;  t_bus.dat_w = '0;  t_bus.sel = '0;  t_bus.we = 1'b0;
        t_bus.cti = '0;  t_bus.bte = '0;    t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        i_bus.ack = 1'b0; i_bus.err = 1'b0; i_bus.dat_r = '0;
        t2_bus.adr = '0; t2_bus.dat_w = '0; t2_bus.sel = '0; t2_bus.we = 1'b0;
        t2_bus.cti = '0; t2_bus.bte = '0;   t2_bus.cyc = 1'b0; t2_bus.stb = 1'b0;
        i2_bus.ack = 1'b0; i2_bus.err = 1'b0; i2_bus.dat_r = '0;

        // reset state
        step();
        step();
        check("rst_outputs", {t_bus.ack, t_bus.err, t_bus.dat_r, i_bus.cyc, i_bus.stb, i_bus.we,
                              i_bus.adr, i_bus.dat_w, i_bus.sel, i_bus.cti, i_bus.bte, to1, cnt1}, '0);
        rst = 1'b0;
        step();

        // write, acked in first REQ cycle; burst hints must be stripped
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1; t_bus.we = 1'b1; t_bus.adr = 32'h1000;
        t_bus.dat_w = 32'hA5A5A5A5; t_bus.sel = 4'hF; t_bus.cti = 3'b010; t_bus.bte = 2'b01;
        check("wr_c0_stb", i_bus.stb, 1'b0);
        step();
        check("wr_c1_req", {i_bus.cyc, i_bus.stb, i_bus.we, i_bus.adr, i_bus.dat_w, i_bus.sel, i_bus.cti, i_bus.bte},
                           {1'b1, 1'b1, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 3'b000, 2'b00});
        check("wr_c1_tack", t_bus.ack, 1'b0);
        i_bus.ack = 1'b1;
        step();
        i_bus.ack = 1'b0;
        check("wr_c2_resp", {i_bus.stb, t_bus.ack, t_bus.err}, 3'b010);
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0; t_bus.cti = 3'b000; t_bus.bte = 2'b00;
        step();
        check("wr_c3_done", {t_bus.ack, i_bus.stb}, 2'b00);

        // read that times out (TIMEOUT=4)
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1; t_bus.we = 1'b0; t_bus.adr = 32'h2000;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("to_c%0d_wait", k), {i_bus.stb, t_bus.err}, 2'b10);
        end
        step();
        check("to_c5_resp", {t_bus.err, t_bus.ack, to1, t_bus.dat_r, i_bus.stb}, {1'b1, 1'b0, 1'b1, 32'h0, 1'b0});
        check("to_c5_count", cnt1, 8'd1);
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        step();
        check("to_c6_pulse", {to1, t_bus.err}, 2'b00);

        // ACK+ERR together on the last count: ERR wins, no timeout
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1; i_bus.dat_r = 32'hDEADBEEF;
        step(); step(); step(); step();
        i_bus.ack = 1'b1; i_bus.err = 1'b1;
        step();
        i_bus.ack = 1'b0; i_bus.err = 1'b0;
        check("ae_c5_resp", {t_bus.err, t_bus.ack, to1, t_bus.dat_r}, {1'b1, 1'b0, 1'b0, 32'h0});
        check("ae_c5_count", cnt1, 8'd1);
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        step();

        // abort: CYC dropped in cycle 2, peripheral acks in cycle 3
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1;
        step(); step();
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        step();
        i_bus.ack = 1'b1; i_bus.dat_r = 32'h12345678;
        step();
        i_bus.ack = 1'b0;
        check("ab_c4_noresp", {t_bus.ack, t_bus.err, t_bus.dat_r, i_bus.stb}, '0);
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1;
        step();
        check("ab_c5_idle", i_bus.stb, 1'b0);
        step();
        check("ab_c6_newreq", {i_bus.stb, i_bus.we}, 2'b10);
        i_bus.ack = 1'b1; i_bus.dat_r = 32'hCAFEF00D;
        step();
        i_bus.ack = 1'b0;
        check("rd_ack_data", {t_bus.ack, t_bus.err, t_bus.dat_r}, {1'b1, 1'b0, 32'hCAFEF00D});
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        step();

        // abort followed by timeout: silent upstream, pulse and count still happen
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1;
        step();
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        step(); step(); step(); step();
        check("abto_c5", {t_bus.err, t_bus.ack, to1}, 3'b001);
        check("abto_count", cnt1, 8'd2);
        step();

        // reset in cycle 2 of an outstanding request
        t_bus.cyc = 1'b1; t_bus.stb = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_c3_cyc", {i_bus.cyc, i_bus.stb}, 2'b00);
        check("mr_c3_count", cnt1, 8'd0);
        t_bus.cyc = 1'b0; t_bus.stb = 1'b0;
        i_bus.ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mr_quiet%0d", k), {t_bus.ack, t_bus.err, i_bus.cyc}, 3'b000);
        end
        i_bus.ack = 1'b0;

        // saturation on the TIMEOUT=2 instance: back-to-back timeouts every 4 cycles
        t2_bus.cyc = 1'b1; t2_bus.stb = 1'b1;
        pulses = 0; v254 = '0; v255 = '0;
        for (int n = 1; n <= 1200; n++) begin
            step();
            if (to2) begin
                pulses++;
                if (pulses == 254) v254 = cnt2;
                if (pulses == 255) v255 = cnt2;
            end
        end
        t2_bus.cyc = 1'b0; t2_bus.stb = 1'b0;
        check("sat_pulses", pulses, 300);
        check("sat_at254", v254, 8'd254);
        check("sat_at255", v255, 8'd255);
        check("sat_final", cnt2, 8'd255);
        step();
        rst = 1'b1;
        step();
        check("rst2_outputs", {t2_bus.ack, t2_bus.err, t2_bus.dat_r, i2_bus.cyc, i2_bus.stb, i2_bus.we,
                               i2_bus.adr, i2_bus.dat_w, i2_bus.sel, i2_bus.cti, i2_bus.bte, to2, cnt2}, '0);
        check("rst1_outputs", {t_bus.ack, t_bus.err, t_bus.dat_r, i_bus.cyc, i_bus.stb, i_bus.we,
                               i_bus.adr, i_bus.dat_w, i_bus.sel, i_bus.cti, i_bus.bte, to1, cnt1}, '0);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
